// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default frame constants
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DATA_BITS_DEFAULT  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous RX pin, resets to idle-high
module uart_rx_sync (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s
);

    logic rx_meta;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled mid-bit sampling and framing-error detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       data_corrupted
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic        rx_s;
    uart_state_t state, state_next;
    logic [TW-1:0] tick, tick_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic [7:0]  data_out_next;
    logic        ready_next, corrupted_next;

    uart_rx_sync u_sync (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .rx      (RX),
        .rx_s    (rx_s)
    );

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            tick           <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            data_out       <= '0;
            data_ready     <= 1'b0;
            data_corrupted <= 1'b0;
        end else begin
            state          <= state_next;
            tick           <= tick_next;
            bit_idx        <= bit_idx_next;
            shift          <= shift_next;
            data_out       <= data_out_next;
            data_ready     <= ready_next;
            data_corrupted <= corrupted_next;
        end
    end

    always_comb begin
        state_next     = state;
        tick_next      = tick;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        data_out_next  = data_out;
        ready_next     = 1'b0;
        corrupted_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    tick_next  = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high here means the low was a glitch.
                if (tick == HALF_LAST) begin
                    tick_next    = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            DATA: begin
                if (tick == FULL_LAST) begin
                    tick_next           = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            STOP: begin
                if (tick == FULL_LAST) begin
                    tick_next = '0;
                    if (rx_s) begin
                        data_out_next = shift;
                        ready_next    = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        corrupted_next = 1'b1;
                        state_next     = BREAK_WAIT;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            BREAK_WAIT: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS = 16;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       RX      = 1'b1;
    logic [7:0] data_out;
    logic       data_ready;
    logic       data_corrupted;

    int tests = 0;
    int fails = 0;

    int ready_cnt   = 0;
    int corrupt_cnt = 0;
    int wide_cnt    = 0;
    int both_cnt    = 0;
    logic prev_ready = 1'b0;
    logic prev_corr  = 1'b0;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .sys_clk        (sys_clk),
        .reset_n        (reset_n),
        .RX             (RX),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .data_corrupted (data_corrupted)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (data_ready) ready_cnt++;
        if (data_corrupted) corrupt_cnt++;
        if ((data_ready && prev_ready) || (data_corrupted && prev_corr)) wide_cnt++;
        if (data_ready && data_corrupted) both_cnt++;
        prev_ready = data_ready;
        prev_corr  = data_corrupted;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        RX = v;
        repeat (OS) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    int r0, c0;

    initial begin
        // Reset
        reset_n = 1'b0;
        RX      = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_ready", 32'(data_ready), 32'h0);
        check("reset_corrupted", 32'(data_corrupted), 32'h0);
        @(negedge sys_clk);
        reset_n = 1'b1;

        // Glitch rejection
        send_bit(1'b1);
        r0 = ready_cnt; c0 = corrupt_cnt;
        RX = 1'b0;
        repeat (4) @(negedge sys_clk);
        RX = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("glitch_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("glitch_no_corrupt", 32'(corrupt_cnt - c0), 32'd0);
        check("glitch_state_idle", 32'(dut.state), 32'(IDLE));

        // Back-to-back good frames
        r0 = ready_cnt;
        send_frame(8'h8B, 1'b1);
        check("frame1_ready_count", 32'(ready_cnt - r0), 32'd1);
        check("frame1_data", 32'(data_out), 32'h8B);
        send_frame(8'h55, 1'b1);
        check("frame2_ready_count", 32'(ready_cnt - r0), 32'd2);
        check("frame2_data", 32'(data_out), 32'h55);
        send_frame(8'h0E, 1'b1);
        check("frame3_ready_count", 32'(ready_cnt - r0), 32'd3);
        check("frame3_data", 32'(data_out), 32'h0E);

        // Framing error: line held low
        r0 = ready_cnt; c0 = corrupt_cnt;
        RX = 1'b0;
        repeat (13 * OS) @(negedge sys_clk);
        check("ferr_corrupt_count", 32'(corrupt_cnt - c0), 32'd1);
        check("ferr_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("ferr_data_kept", 32'(data_out), 32'h0E);
        check("ferr_break_wait", 32'(dut.state), 32'(BREAK_WAIT));
        RX = 1'b1;
        repeat (2 * OS) @(negedge sys_clk);
        check("ferr_post_corrupt", 32'(corrupt_cnt - c0), 32'd1);
        check("ferr_post_idle", 32'(dut.state), 32'(IDLE));

        // Reset during data bit 4
        r0 = ready_cnt; c0 = corrupt_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        RX = 1'b0;
        repeat (8) @(negedge sys_clk);
        reset_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check("midrst_data_out", 32'(data_out), 32'h00);
        check("midrst_ready", 32'(data_ready), 32'h0);
        check("midrst_corrupted", 32'(data_corrupted), 32'h0);
        check("midrst_state_idle", 32'(dut.state), 32'(IDLE));
        @(negedge sys_clk);
        RX = 1'b1;
        @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (OS) @(negedge sys_clk);
        send_frame(8'hA5, 1'b1);
        check("after_rst_ready_count", 32'(ready_cnt - r0), 32'd1);
        check("after_rst_no_corrupt", 32'(corrupt_cnt - c0), 32'd0);
        check("after_rst_data", 32'(data_out), 32'hA5);

        repeat (4) @(negedge sys_clk);
        check("flags_single_cycle", 32'(wide_cnt), 32'd0);
        check("flags_exclusive", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
